// File: rtl/arm_pkg.sv
// Shared ARM pipeline constants: default datapath widths and architectural register indices.
package arm_pkg;
    localparam int ARM_DATA_W   = 32;
    localparam int ARM_ADDR_W   = 4;
    localparam int ARM_NUM_REGS = 15;
    localparam int REG_SP       = 13;
    localparam int REG_LR       = 14;
endpackage

// File: rtl/reg_scoreboard.sv
// Per-register pending-write counters feeding hazard flags, issue stall and busy map.
module reg_scoreboard
    import arm_pkg::*;
#(
    parameter int NUM_REGS = ARM_NUM_REGS,
    parameter int ADDR_W   = ARM_ADDR_W,
    parameter int PEND_W   = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                issue_en,
    input  logic [ADDR_W-1:0]   issue_dest,
    input  logic                wb_en,
    input  logic [ADDR_W-1:0]   wb_dest,
    input  logic [ADDR_W-1:0]   src1,
    input  logic [ADDR_W-1:0]   src2,
    input  logic [ADDR_W-1:0]   src3,
    output logic                haz1,
    output logic                haz2,
    output logic                haz3,
    output logic                issue_stall,
    output logic [NUM_REGS-1:0] busy
);
    localparam logic [PEND_W-1:0] CNT_MAX = '1;
    localparam logic [PEND_W-1:0] CNT_ONE = PEND_W'(1);

    logic [PEND_W-1:0]   cnt_q [NUM_REGS];
    logic [PEND_W-1:0]   cnt_d [NUM_REGS];
    logic [NUM_REGS-1:0] inc_v;
    logic [NUM_REGS-1:0] dec_v;
    logic                issue_hit;
    logic                wb_hit;
    logic [PEND_W-1:0]   pend_issue;
    logic [PEND_W-1:0]   pend1;
    logic [PEND_W-1:0]   pend2;
    logic [PEND_W-1:0]   pend3;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return int'(a) < NUM_REGS;
    endfunction

    // A write retiring the last outstanding count is already covered by the bypass.
    function automatic logic haz_calc(input logic [ADDR_W-1:0] src,
                                      input logic [PEND_W-1:0] pend,
                                      input logic              wbh,
                                      input logic [ADDR_W-1:0] wbd);
        return (pend != '0) && !(wbh && (wbd == src) && (pend == CNT_ONE));
    endfunction

    always_comb begin
        issue_hit   = issue_en && in_range(issue_dest);
        wb_hit      = wb_en && in_range(wb_dest);
        pend_issue  = issue_hit ? cnt_q[issue_dest] : '0;
        pend1       = in_range(src1) ? cnt_q[src1] : '0;
        pend2       = in_range(src2) ? cnt_q[src2] : '0;
        pend3       = in_range(src3) ? cnt_q[src3] : '0;
        issue_stall = issue_hit && (pend_issue == CNT_MAX) && !(wb_hit && (wb_dest == issue_dest));
        haz1        = haz_calc(src1, pend1, wb_hit, wb_dest);
        haz2        = haz_calc(src2, pend2, wb_hit, wb_dest);
        haz3        = haz_calc(src3, pend3, wb_hit, wb_dest);
        inc_v       = '0;
        dec_v       = '0;
        busy        = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            inc_v[i] = issue_hit && (issue_dest == ADDR_W'(i)) && !issue_stall;
            dec_v[i] = wb_hit && (wb_dest == ADDR_W'(i));
            busy[i]  = (cnt_q[i] != '0);
            cnt_d[i] = cnt_q[i];
            if (inc_v[i] && !dec_v[i]) begin
                cnt_d[i] = cnt_q[i] + CNT_ONE;
            end else if (dec_v[i] && !inc_v[i] && (cnt_q[i] != '0)) begin
                cnt_d[i] = cnt_q[i] - CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end
endmodule

// File: rtl/reg_file_mp.sv
// Three-read / two-write register file with same-cycle write bypass and pending-write scoreboard.
module reg_file_mp
    import arm_pkg::*;
#(
    parameter int DATA_W     = ARM_DATA_W,
    parameter int NUM_REGS   = ARM_NUM_REGS,
    parameter int ADDR_W     = ARM_ADDR_W,
    parameter int PEND_W     = 2,
    parameter int INIT_INDEX = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   src1,
    input  logic [ADDR_W-1:0]   src2,
    input  logic [ADDR_W-1:0]   src3,
    output logic [DATA_W-1:0]   reg1,
    output logic [DATA_W-1:0]   reg2,
    output logic [DATA_W-1:0]   reg3,
    input  logic                wb_en,
    input  logic [ADDR_W-1:0]   wb_dest,
    input  logic [DATA_W-1:0]   wb_data,
    input  logic                base_en,
    input  logic [ADDR_W-1:0]   base_dest,
    input  logic [DATA_W-1:0]   base_data,
    input  logic                issue_en,
    input  logic [ADDR_W-1:0]   issue_dest,
    output logic                haz1,
    output logic                haz2,
    output logic                haz3,
    output logic                issue_stall,
    output logic [NUM_REGS-1:0] busy
);
    logic [DATA_W-1:0] regs_q [NUM_REGS];

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return int'(a) < NUM_REGS;
    endfunction

    // Port A has priority over port B both for storage and for the bypass.
    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] a,
                                                    input logic [DATA_W-1:0] stored);
        if (!in_range(a)) begin
            return '0;
        end else if (wb_en && (wb_dest == a)) begin
            return wb_data;
        end else if (base_en && (base_dest == a)) begin
            return base_data;
        end
        return stored;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= (INIT_INDEX != 0) ? DATA_W'(i) : '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wb_en && (wb_dest == ADDR_W'(i))) begin
                    regs_q[i] <= wb_data;
                end else if (base_en && (base_dest == ADDR_W'(i))) begin
                    regs_q[i] <= base_data;
                end
            end
        end
    end

    always_comb begin
        reg1 = read_port(src1, in_range(src1) ? regs_q[src1] : '0);
        reg2 = read_port(src2, in_range(src2) ? regs_q[src2] : '0);
        reg3 = read_port(src3, in_range(src3) ? regs_q[src3] : '0);
    end

    reg_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W),
        .PEND_W   (PEND_W)
    ) u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .issue_en    (issue_en),
        .issue_dest  (issue_dest),
        .wb_en       (wb_en),
        .wb_dest     (wb_dest),
        .src1        (src1),
        .src2        (src2),
        .src3        (src3),
        .haz1        (haz1),
        .haz2        (haz2),
        .haz3        (haz3),
        .issue_stall (issue_stall),
        .busy        (busy)
    );
endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: expectations queued as stimulus is driven, checked once outputs settle.
module tb_reg_file_mp;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  src1 = '0, src2 = '0, src3 = '0;
    logic [31:0] reg1, reg2, reg3;
    logic        wb_en = 1'b0, base_en = 1'b0, issue_en = 1'b0;
    logic [3:0]  wb_dest = '0, base_dest = '0, issue_dest = '0;
    logic [31:0] wb_data = '0, base_data = '0;
    logic        haz1, haz2, haz3, issue_stall;
    logic [14:0] busy;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } item_t;

    item_t q[$];
    int    n_assert = 0;
    int    n_fail   = 0;

    localparam int S_REG1 = 0, S_REG2 = 1, S_REG3 = 2, S_HAZ1 = 3, S_HAZ2 = 4,
                   S_HAZ3 = 5, S_STALL = 6, S_BUSY = 7;

    reg_file_mp dut (
        .clk         (clk),
        .rst         (rst),
        .src1        (src1),
        .src2        (src2),
        .src3        (src3),
        .reg1        (reg1),
        .reg2        (reg2),
        .reg3        (reg3),
        .wb_en       (wb_en),
        .wb_dest     (wb_dest),
        .wb_data     (wb_data),
        .base_en     (base_en),
        .base_dest   (base_dest),
        .base_data   (base_data),
        .issue_en    (issue_en),
        .issue_dest  (issue_dest),
        .haz1        (haz1),
        .haz2        (haz2),
        .haz3        (haz3),
        .issue_stall (issue_stall),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            S_REG1:  return reg1;
            S_REG2:  return reg2;
            S_REG3:  return reg3;
            S_HAZ1:  return {31'd0, haz1};
            S_HAZ2:  return {31'd0, haz2};
            S_HAZ3:  return {31'd0, haz3};
            S_STALL: return {31'd0, issue_stall};
            default: return {17'd0, busy};
        endcase
    endfunction

    task automatic expect_val(input string tag, input int sel, input logic [31:0] exp);
        item_t it;
        it.tag = tag;
        it.sel = sel;
        it.exp = exp;
        q.push_back(it);
    endtask

    task automatic drain();
        item_t       it;
        logic [31:0] obs;
        #1;
        while (q.size() > 0) begin
            it  = q.pop_front();
            obs = observe(it.sel);
            n_assert++;
            assert (obs === it.exp) else begin
                n_fail++;
                $error("FAIL %s: observed %h expected %h", it.tag, obs, it.exp);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1 rst = 1'b0;
        src1 = 4'd5; src2 = 4'd14; src3 = 4'd15;
        expect_val("rst_reg1", S_REG1, 32'd5);
        expect_val("rst_reg2_lr", S_REG2, 32'd14);
        expect_val("rst_reg3_oor", S_REG3, 32'd0);
        expect_val("rst_busy", S_BUSY, 32'd0);
        expect_val("rst_stall", S_STALL, 32'd0);
        expect_val("rst_haz1", S_HAZ1, 32'd0);
        drain();
        @(negedge clk) rst = 1'b1;

        // Both write ports to R3: port A wins in bypass and in storage.
        src1 = 4'd3;
        wb_en = 1'b1; wb_dest = 4'd3; wb_data = 32'hAAAA_0000;
        base_en = 1'b1; base_dest = 4'd3; base_data = 32'h0000_1234;
        expect_val("dual_bypass", S_REG1, 32'hAAAA_0000);
        drain();
        tick();
        wb_en = 1'b0; base_en = 1'b0;
        expect_val("dual_stored", S_REG1, 32'hAAAA_0000);
        expect_val("dual_busy", S_BUSY, 32'd0);
        drain();

        // Port B bypass on R7, plus an out-of-range write that must be ignored.
        src2 = 4'd7; src3 = 4'd15;
        base_en = 1'b1; base_dest = 4'd7; base_data = 32'hDEAD_BEEF;
        wb_en = 1'b1; wb_dest = 4'd15; wb_data = 32'h0BAD_0BAD;
        expect_val("base_bypass", S_REG2, 32'hDEAD_BEEF);
        expect_val("oor_read_during_wr", S_REG3, 32'd0);
        expect_val("r3_unaffected", S_REG1, 32'hAAAA_0000);
        drain();
        tick();
        base_en = 1'b0; wb_en = 1'b0;
        expect_val("base_stored", S_REG2, 32'hDEAD_BEEF);
        expect_val("oor_busy", S_BUSY, 32'd0);
        drain();

        // Three issues to R4 saturate its counter; the fourth must stall.
        src1 = 4'd4;
        issue_en = 1'b1; issue_dest = 4'd4;
        for (int k = 0; k < 3; k++) begin
            expect_val("issue_nostall", S_STALL, 32'd0);
            drain();
            tick();
        end
        expect_val("sat_busy", S_BUSY, 32'h0000_0010);
        expect_val("sat_haz1", S_HAZ1, 32'd1);
        expect_val("sat_stall", S_STALL, 32'd1);
        drain();
        tick();
        issue_en = 1'b0;
        expect_val("after_stall_busy", S_BUSY, 32'h0000_0010);
        drain();

        // Retire three writes; only the last one clears the hazard in its own cycle.
        wb_en = 1'b1; wb_dest = 4'd4;
        wb_data = 32'h4000_0001;
        expect_val("wb1_haz1", S_HAZ1, 32'd1);
        drain();
        tick();
        wb_data = 32'h4000_0002;
        expect_val("wb2_haz1", S_HAZ1, 32'd1);
        drain();
        tick();
        wb_data = 32'h4000_0003;
        expect_val("wb3_haz1", S_HAZ1, 32'd0);
        expect_val("wb3_bypass", S_REG1, 32'h4000_0003);
        drain();
        tick();
        wb_en = 1'b0;
        expect_val("retired_busy", S_BUSY, 32'd0);
        expect_val("retired_haz1", S_HAZ1, 32'd0);
        expect_val("retired_reg1", S_REG1, 32'h4000_0003);
        drain();

        // Issue and WB to R2 together with one pending: count stays at one.
        src2 = 4'd2;
        issue_en = 1'b1; issue_dest = 4'd2;
        tick();
        wb_en = 1'b1; wb_dest = 4'd2; wb_data = 32'h2222_2222;
        expect_val("sim_stall", S_STALL, 32'd0);
        drain();
        tick();
        issue_en = 1'b0; wb_en = 1'b0;
        expect_val("sim_haz2", S_HAZ2, 32'd1);
        expect_val("sim_busy", S_BUSY, 32'h0000_0004);
        expect_val("sim_reg2", S_REG2, 32'h2222_2222);
        drain();

        // Asynchronous reset in the middle of a cycle with R1 and R2 pending.
        src1 = 4'd1; src3 = 4'd3;
        issue_en = 1'b1; issue_dest = 4'd1;
        tick();
        issue_en = 1'b0;
        expect_val("pre_rst_busy", S_BUSY, 32'h0000_0006);
        expect_val("pre_rst_haz1", S_HAZ1, 32'd1);
        drain();
        #2 rst = 1'b0;
        expect_val("mid_rst_busy", S_BUSY, 32'd0);
        expect_val("mid_rst_haz1", S_HAZ1, 32'd0);
        expect_val("mid_rst_haz2", S_HAZ2, 32'd0);
        expect_val("mid_rst_reg1", S_REG1, 32'd1);
        expect_val("mid_rst_reg2", S_REG2, 32'd2);
        expect_val("mid_rst_reg3", S_REG3, 32'd3);
        drain();
        @(negedge clk) rst = 1'b1;

        // WB to R1 with no pending issue: data lands, counter stays at zero.
        wb_en = 1'b1; wb_dest = 4'd1; wb_data = 32'h5555_5555;
        tick();
        wb_en = 1'b0;
        expect_val("post_rst_reg1", S_REG1, 32'h5555_5555);
        expect_val("post_rst_busy", S_BUSY, 32'd0);
        expect_val("post_rst_haz1", S_HAZ1, 32'd0);
        drain();
        issue_en = 1'b1; issue_dest = 4'd1;
        tick();
        issue_en = 1'b0;
        expect_val("no_underflow_busy", S_BUSY, 32'h0000_0002);
        expect_val("no_underflow_haz1", S_HAZ1, 32'd1);
        drain();

        // Out-of-range issue is ignored and never stalls.
        issue_en = 1'b1; issue_dest = 4'd15; src3 = 4'd15;
        expect_val("oor_issue_stall", S_STALL, 32'd0);
        expect_val("oor_haz3", S_HAZ3, 32'd0);
        drain();
        tick();
        issue_en = 1'b0;
        expect_val("oor_issue_busy", S_BUSY, 32'h0000_0002);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
- Parametrised multi-port register file for the ARM pipeline.
- Provides 3 read ports (ID stage: Rn, Rm, Rs/Rd-for-store) and 2 write ports: WB result, plus base-register writeback from EX.
- Same-cycle write-to-read bypass.
- Per-register pending-write scoreboard that drives hazard flags to the hazard unit.

Parameters:
DATA_W, 32, register width in bits
NUM_REGS, 15, number of architectural registers (R0..R14; PC is held elsewhere)
ADDR_W, 4, register index width; must satisfy 2**ADDR_W >= NUM_REGS
PEND_W, 2, width of each per-register pending counter (max outstanding writes = 2**PEND_W-1)
INIT_INDEX, 1, 1: register i resets to value i; 0: all registers reset to 0

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-low reset
src1  in  ADDR_W  read address port 1
src2  in  ADDR_W  read address port 2
src3  in  ADDR_W  read address port 3
reg1  out  DATA_W  read data port 1
reg2  out  DATA_W  read data port 2
reg3  out  DATA_W  read data port 3
wb_en  in  1  write enable, port A (WB stage)
wb_dest  in  ADDR_W  write address, port A
wb_data  in  DATA_W  write data, port A
base_en  in  1  write enable, port B (EX base writeback)
base_dest  in  ADDR_W  write address, port B
base_data  in  DATA_W  write data, port B
issue_en  in  1  instruction leaving ID will write issue_dest via port A
issue_dest  in  ADDR_W  destination of issuing instruction
haz1  out  1  src1 has an outstanding write not yet satisfied
haz2  out  1  src2 has an outstanding write not yet satisfied
haz3  out  1  src3 has an outstanding write not yet satisfied
issue_stall  out  1  pending counter of issue_dest is saturated; issue must not proceed
busy  out  NUM_REGS  bit i = pending counter i non-zero

Behaviour:
- Reset (rst=0, asynchronous):
  - Register i <= i if INIT_INDEX=1, else 0.
  - All pending counters <= 0.
  - Consequently haz*=0, busy=0, issue_stall=0; reg1..3 show reset contents.
- Writes: registered on rising clk while rst=1.
  - Port A writes when wb_en=1; port B writes when base_en=1.
  - Both enabled with the same dest: port A data is stored.
  - Any dest >= NUM_REGS: write ignored.
- Reads: combinational, zero latency.
  - Address >= NUM_REGS: returns 0.
  - Bypass: if src matches an enabled write dest in the same cycle, output that write data (port A over port B) instead of the stored value. The value written at the edge is therefore visible in the same cycle as the write.
- Scoreboard: one PEND_W-bit counter per register.
  - Increment when issue_en=1 and issue_dest=i and counter not saturated.
  - Decrement when wb_en=1 and wb_dest=i and counter non-zero.
  - Both in the same cycle on the same register: unchanged.
  - Decrement at zero: held at 0 (WB without prior issue is legal, e.g. after reset; no underflow).
  - Port B writes never touch counters.
- issue_stall = issue_en & (counter[issue_dest] == all-ones) & (no same-cycle wb_en to issue_dest).
  - When issue_stall=1, the increment is suppressed and the requester must hold.
- hazN = (counter[srcN] != 0) & !(wb_en & wb_dest==srcN & counter[srcN]==1).
  - I.e. the last outstanding write retiring this cycle is covered by the bypass.
- Out-of-range src or issue_dest: haz=0, no counter change, issue_stall=0.
- Reset asserted mid-operation: all state cleared immediately; in-flight WB writes after reset release are accepted normally; counters stay at 0 by the underflow rule.

Decomposition:
- Shared package (arm_pkg): DATA_W / ADDR_W defaults, NUM_REGS, register index constants (REG_SP=13, REG_LR=14).
- Natural sub-module: reg_scoreboard.
  - Contains the pending counters, issue_stall, haz and busy logic.
  - Parametrised by NUM_REGS/ADDR_W/PEND_W; instantiated once.
- Storage array, write ports and bypass muxes stay in reg_file_mp.

Test Plan:
- Reset, INIT_INDEX=1: rst=0 then 1; src1=5, src2=14, src3=15 -> reg1=5, reg2=14, reg3=0; busy=0.
- Dual write, same dest: wb_en=1 wb_dest=3 wb_data=0xAAAA_0000 and base_en=1 base_dest=3 base_data=0x1234.
  - Same cycle, src1=3 -> reg1=0xAAAA_0000.
  - After the edge, reg1 still 0xAAAA_0000.
- Bypass: src2=7, base_en=1 base_dest=7 base_data=0xDEAD_BEEF -> reg2=0xDEAD_BEEF in that cycle, before the edge.
- Scoreboard:
  - issue_en dest=4 for 3 cycles -> busy[4]=1, counter=3.
  - 4th issue to R4 -> issue_stall=1, counter stays 3.
  - Three wb_en dest=4 -> haz1 (src1=4) stays 1 until the cycle of the third WB, where haz1=0; afterwards busy[4]=0.
- Simultaneous issue_en dest=2 and wb_en dest=2 with counter=1 -> counter stays 1, haz (src=2) stays 1.
- Reset mid-flight: counters for R1, R2 non-zero, assert rst=0 between edges -> busy=0 and haz*=0 immediately; R1 back to 1.
  - Subsequent wb_en dest=1 with counter=0 -> data written, counter stays 0.
